// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control sequencer for the shared 32-bit MIPS-subset ALU:
// fetch, decode, execute, evaluate, then branch, memory access or write-back.
module alu_seq_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter int          WAIT_MAX  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic        alu_valid,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  input  logic [31:0] rt_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [1:0]  rf_wsel,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  trap
);

  localparam int WW = $clog2(WAIT_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_EVAL, S_MEM, S_WB, S_HALTED
  } state_t;

  state_t         r_state, w_next;
  logic [31:0]    r_pc, r_instr, r_addr, r_retired;
  logic [1:0]     r_trap, r_wsel;
  logic [WW-1:0]  r_wait;

  logic [5:0]     w_op, w_fn;
  logic           w_rtype, w_supported, w_ovf_op, w_branch, w_lw, w_sw, w_slt;
  logic           w_retire, w_timeout, w_ovf_trap, w_wait_done;
  logic [4:0]     w_waddr;
  logic           w_unused;

  assign w_op        = r_instr[31:26];
  assign w_fn        = r_instr[5:0];
  assign w_rtype     = (w_op == 6'h00);
  assign w_waddr     = w_rtype ? r_instr[15:11] : r_instr[20:16];
  assign w_wait_done = (r_wait == WW'(WAIT_MAX - 1));
  // less-than is folded into the write-data mux outside this block
  assign w_unused    = alu_flags[1];

  always_comb begin
    w_supported = 1'b0;
    w_ovf_op    = 1'b0;
    w_branch    = 1'b0;
    w_lw        = 1'b0;
    w_sw        = 1'b0;
    w_slt       = 1'b0;
    case (w_op)
      6'h00: case (w_fn)
        6'h00, 6'h02, 6'h03, 6'h21, 6'h23,
        6'h24, 6'h25, 6'h26, 6'h27: w_supported = 1'b1;
        6'h20, 6'h22: begin w_supported = 1'b1; w_ovf_op = 1'b1; end
        6'h2A, 6'h2B: begin w_supported = 1'b1; w_slt    = 1'b1; end
        default: ;
      endcase
      6'h04, 6'h05: begin w_supported = 1'b1; w_branch = 1'b1; end
      6'h08:        begin w_supported = 1'b1; w_ovf_op = 1'b1; end
      6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: w_supported = 1'b1;
      6'h0A, 6'h0B: begin w_supported = 1'b1; w_slt = 1'b1; end
      6'h23:        begin w_supported = 1'b1; w_lw  = 1'b1; end
      6'h2B:        begin w_supported = 1'b1; w_sw  = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_retire   = 1'b0;
    w_timeout  = 1'b0;
    w_ovf_trap = 1'b0;
    case (r_state)
      S_IDLE:   if (start) w_next = S_FETCH;
      S_FETCH:
        if (imem_ready) w_next = S_DECODE;
        else if (w_wait_done) begin w_timeout = 1'b1; w_next = S_HALTED; end
      S_DECODE:
        if (r_instr == HALT_WORD) w_next = S_HALTED;
        else if (!w_supported) begin w_retire = 1'b1; w_next = S_FETCH; end
        else w_next = S_EXEC;
      S_EXEC:   w_next = S_EVAL;
      S_EVAL:
        if (w_ovf_op && alu_flags[2]) begin w_ovf_trap = 1'b1; w_next = S_HALTED; end
        else if (w_branch) begin w_retire = 1'b1; w_next = S_FETCH; end
        else if (w_lw || w_sw) w_next = S_MEM;
        else w_next = S_WB;
      S_MEM:
        if (dmem_ready) begin
          w_retire = w_sw;
          w_next   = w_sw ? S_FETCH : S_WB;
        end else if (w_wait_done) begin w_timeout = 1'b1; w_next = S_HALTED; end
      S_WB:     begin w_retire = 1'b1; w_next = S_FETCH; end
      S_HALTED: if (start) w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_addr    <= '0;
      r_retired <= '0;
      r_trap    <= 2'b00;
      r_wsel    <= 2'b00;
      r_wait    <= '0;
    end else begin
      r_state <= w_next;
      // wait counter restarts on every state entry
      if (w_next != r_state)                         r_wait <= '0;
      else if (r_state == S_FETCH || r_state == S_MEM) r_wait <= r_wait + WW'(1);
      else                                           r_wait <= '0;

      if (w_retire)   r_retired <= r_retired + 32'd1;
      if (w_timeout)  r_trap    <= 2'b10;
      if (w_ovf_trap) r_trap    <= 2'b01;

      case (r_state)
        S_IDLE:   if (start) r_pc <= RESET_PC;
        S_HALTED: if (start) begin r_pc <= RESET_PC; r_trap <= 2'b00; end
        S_FETCH:  if (imem_ready) begin
          r_instr <= imem_rdata;
          r_pc    <= r_pc + 32'd4;
        end
        S_EVAL: begin
          r_addr <= alu_result;
          r_wsel <= w_slt ? 2'b10 : 2'b00;
          // pc already points past the branch
          if (w_branch && alu_flags[0])
            r_pc <= r_pc + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        end
        S_MEM:    if (dmem_ready && w_lw) r_wsel <= 2'b01;
        default: ;
      endcase
    end
  end

  assign imem_req   = (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign instr      = r_instr;
  assign rs_addr    = r_instr[25:21];
  assign rt_addr    = r_instr[20:16];
  assign alu_valid  = (r_state == S_EXEC);
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = (r_state == S_MEM) && w_sw;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = rt_data;
  assign rf_we      = (r_state == S_WB) && (w_waddr != 5'd0);
  assign rf_waddr   = w_waddr;
  assign rf_wsel    = r_wsel;
  assign pc         = r_pc;
  assign retired    = r_retired;
  assign busy       = (r_state != S_IDLE) && (r_state != S_HALTED);
  assign halted     = (r_state == S_HALTED);
  assign trap       = r_trap;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: walks instructions cycle by cycle and
// checks strobes, pc, retired count and trap causes against hand values.
module tb_alu_seq_ctrl;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0, instr;
  logic [4:0]  rs_addr, rt_addr, rf_waddr;
  logic        alu_valid, dmem_req, dmem_we, dmem_ready = 1'b0, rf_we;
  logic [31:0] alu_result = '0, rt_data = '0, dmem_addr, dmem_wdata, pc, retired;
  logic [2:0]  alu_flags = '0;
  logic [1:0]  rf_wsel, trap;
  logic        busy, halted;
  int n_cmp = 0, n_err = 0;

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instr(instr), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .alu_valid(alu_valid), .alu_result(alu_result), .alu_flags(alu_flags),
    .rt_data(rt_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wsel(rf_wsel), .pc(pc),
    .retired(retired), .busy(busy), .halted(halted), .trap(trap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // supply one instruction after dly idle cycles; DUT ends up in DECODE
  task automatic present(input logic [31:0] w, input int dly);
    repeat (dly) tick();
    imem_ready = 1'b1; imem_rdata = w;
    tick();
    imem_ready = 1'b0; imem_rdata = 32'h0BAD_0BAD;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
    n_cmp++; if (retired !== 32'h0) begin n_err++; $display("FAIL rst_retired: got %h want 0", retired); end
    n_cmp++; if (instr !== 32'h0 || trap !== 2'b00) begin n_err++; $display("FAIL rst_instr_trap: got %h/%b want 0/00", instr, trap); end
    n_cmp++; if ({imem_req, alu_valid, dmem_req, dmem_we, rf_we, busy, halted} !== 7'b0) begin
      n_err++; $display("FAIL rst_strobes: got %b want 0000000", {imem_req, alu_valid, dmem_req, dmem_we, rf_we, busy, halted}); end
    rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL idle_no_start: busy %b req %b want 0 0", busy, imem_req); end
  endtask

  task automatic test_addu();
    pulse_start();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || busy !== 1'b1) begin
      n_err++; $display("FAIL addu_fetch: req %b addr %h busy %b want 1 0 1", imem_req, imem_addr, busy); end
    alu_result = 32'd7; alu_flags = 3'b000;
    present(32'h0022_1821, 0);
    n_cmp++; if (instr !== 32'h0022_1821 || rs_addr !== 5'd1 || rt_addr !== 5'd2) begin
      n_err++; $display("FAIL addu_decode: instr %h rs %0d rt %0d want 00221821 1 2", instr, rs_addr, rt_addr); end
    n_cmp++; if (pc !== 32'h4 || imem_req !== 1'b0) begin n_err++; $display("FAIL addu_pc: pc %h req %b want 4 0", pc, imem_req); end
    start = 1'b1;  // ignored while busy
    tick();
    n_cmp++; if (alu_valid !== 1'b1) begin n_err++; $display("FAIL addu_exec: alu_valid %b want 1", alu_valid); end
    start = 1'b0;
    tick();
    n_cmp++; if (alu_valid !== 1'b0 || rf_we !== 1'b0) begin n_err++; $display("FAIL addu_eval: alu_valid %b rf_we %b want 0 0", alu_valid, rf_we); end
    tick();
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wsel !== 2'b00) begin
      n_err++; $display("FAIL addu_wb: we %b waddr %0d wsel %b want 1 3 00", rf_we, rf_waddr, rf_wsel); end
    tick();
    n_cmp++; if (rf_we !== 1'b0 || retired !== 32'd1 || imem_addr !== 32'h4 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL addu_done: we %b retired %0d addr %h req %b want 0 1 4 1", rf_we, retired, imem_addr, imem_req); end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 3; i++) begin present(32'hFC00_0000, 0); tick(); end
    n_cmp++; if (retired !== 32'd4 || imem_addr !== 32'h10) begin
      n_err++; $display("FAIL nop_retire: retired %0d addr %h want 4 10", retired, imem_addr); end
    alu_flags = 3'b001;
    present(32'h1000_FFFF, 0); tick(); tick(); tick();
    n_cmp++; if (imem_addr !== 32'h10 || retired !== 32'd5 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL beq_taken: addr %h retired %0d req %b want 10 5 1", imem_addr, retired, imem_req); end
    alu_flags = 3'b000;
    present(32'h1000_FFFF, 0); tick(); tick(); tick();
    n_cmp++; if (imem_addr !== 32'h14 || retired !== 32'd6) begin
      n_err++; $display("FAIL beq_not_taken: addr %h retired %0d want 14 6", imem_addr, retired); end
  endtask

  task automatic test_overflow();
    logic saw_we;
    alu_flags = 3'b100; alu_result = 32'h8000_0000;
    present(32'h0022_1820, 0);
    saw_we = rf_we;
    tick(); saw_we |= rf_we;
    tick(); saw_we |= rf_we;
    tick(); saw_we |= rf_we;
    n_cmp++; if (halted !== 1'b1 || trap !== 2'b01 || busy !== 1'b0) begin
      n_err++; $display("FAIL ovf_halt: halted %b trap %b busy %b want 1 01 0", halted, trap, busy); end
    tick(); tick(); saw_we |= rf_we;
    n_cmp++; if (saw_we !== 1'b0 || retired !== 32'd6 || trap !== 2'b01) begin
      n_err++; $display("FAIL ovf_no_wb: rf_we_seen %b retired %0d trap %b want 0 6 01", saw_we, retired, trap); end
    alu_flags = 3'b000;
    pulse_start();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || trap !== 2'b00 || retired !== 32'd6) begin
      n_err++; $display("FAIL ovf_restart: req %b addr %h trap %b retired %0d want 1 0 00 6", imem_req, imem_addr, trap, retired); end
  endtask

  task automatic test_mem();
    alu_result = 32'h100;
    present(32'h8C25_0008, 3); tick(); tick(); tick();
    alu_result = 32'hDEAD_0000;
    n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100) begin
      n_err++; $display("FAIL lw_mem: req %b we %b addr %h want 1 0 100", dmem_req, dmem_we, dmem_addr); end
    tick(); tick();
    n_cmp++; if (dmem_req !== 1'b1 || rf_we !== 1'b0) begin n_err++; $display("FAIL lw_wait: req %b rf_we %b want 1 0", dmem_req, rf_we); end
    dmem_ready = 1'b1; tick(); dmem_ready = 1'b0;
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wsel !== 2'b01 || dmem_req !== 1'b0) begin
      n_err++; $display("FAIL lw_wb: we %b waddr %0d wsel %b dreq %b want 1 5 01 0", rf_we, rf_waddr, rf_wsel, dmem_req); end
    tick();
    n_cmp++; if (retired !== 32'd7 || imem_addr !== 32'h4) begin n_err++; $display("FAIL lw_done: retired %0d addr %h want 7 4", retired, imem_addr); end
    alu_result = 32'h200; rt_data = 32'hCAFE_BABE;
    present(32'hAC26_000C, 0); tick(); tick(); tick();
    n_cmp++; if (dmem_we !== 1'b1 || dmem_wdata !== 32'hCAFE_BABE || dmem_addr !== 32'h200) begin
      n_err++; $display("FAIL sw_mem: we %b wdata %h addr %h want 1 cafebabe 200", dmem_we, dmem_wdata, dmem_addr); end
    dmem_ready = 1'b1; tick(); dmem_ready = 1'b0;
    n_cmp++; if (rf_we !== 1'b0 || retired !== 32'd8 || imem_addr !== 32'h8 || dmem_req !== 1'b0) begin
      n_err++; $display("FAIL sw_done: rf_we %b retired %0d addr %h dreq %b want 0 8 8 0", rf_we, retired, imem_addr, dmem_req); end
  endtask

  task automatic test_wb_variants();
    alu_result = 32'h1;
    present(32'h0022_202A, 0); tick(); tick(); tick();
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wsel !== 2'b10) begin
      n_err++; $display("FAIL slt_wb: we %b waddr %0d wsel %b want 1 4 10", rf_we, rf_waddr, rf_wsel); end
    tick();
    present(32'h0022_0021, 0); tick(); tick(); tick();
    n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL r0_wb: we %b waddr %0d busy %b want 0 0 1", rf_we, rf_waddr, busy); end
    tick();
    n_cmp++; if (retired !== 32'd10 || imem_addr !== 32'h10) begin n_err++; $display("FAIL r0_retire: retired %0d addr %h want 10 10", retired, imem_addr); end
  endtask

  task automatic test_timeout();
    alu_result = 32'h300;
    present(32'h8C25_0008, 0); tick(); tick(); tick();
    repeat (15) tick();
    n_cmp++; if (dmem_req !== 1'b1 || trap !== 2'b00) begin n_err++; $display("FAIL tmo_early: dreq %b trap %b want 1 00", dmem_req, trap); end
    tick();
    n_cmp++; if (dmem_req !== 1'b0 || halted !== 1'b1 || trap !== 2'b10 || retired !== 32'd10) begin
      n_err++; $display("FAIL tmo_trap: dreq %b halted %b trap %b retired %0d want 0 1 10 10", dmem_req, halted, trap, retired); end
    dmem_ready = 1'b1; tick(); dmem_ready = 1'b0;
    n_cmp++; if (halted !== 1'b1 || trap !== 2'b10) begin n_err++; $display("FAIL tmo_hold: halted %b trap %b want 1 10", halted, trap); end
    pulse_start();
  endtask

  task automatic test_halt_and_reset();
    present(32'hFFFF_FFFF, 0); tick();
    n_cmp++; if (halted !== 1'b1 || retired !== 32'd10 || trap !== 2'b00) begin
      n_err++; $display("FAIL halt_word: halted %b retired %0d trap %b want 1 10 00", halted, retired, trap); end
    pulse_start();
    present(32'hFC00_0000, 0); tick();
    n_cmp++; if (imem_req !== 1'b1 || pc !== 32'h4) begin n_err++; $display("FAIL pre_rst: req %b pc %h want 1 4", imem_req, pc); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || pc !== 32'h0 || retired !== 32'd0) begin
      n_err++; $display("FAIL async_rst: req %b pc %h retired %0d want 0 0 0", imem_req, pc, retired); end
    tick(); rst = 1'b0; tick();
    n_cmp++; if (busy !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL post_rst: busy %b halted %b want 0 0", busy, halted); end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_branch();
    test_overflow();
    test_mem();
    test_wb_variants();
    test_timeout();
    test_halt_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
